// File: rtl/tt_um_jleugeri_ticktocktokens_sequencer.sv
// Tick sequencer for the ticktocktokens core: streams one token count per processor,
// steps the core with a single slow-clock pulse, waits for done, then scans results into events.
module tt_um_jleugeri_ticktocktokens_sequencer #(
    parameter int NUM_PROCESSORS = 10,
    parameter int TOKENS_BITS    = 8,
    parameter int PERIOD_BITS    = 16,
    parameter int DONE_TIMEOUT   = 255,
    parameter int ID_BITS        = $clog2(NUM_PROCESSORS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   start,
    input  logic                   free_run,
    input  logic [PERIOD_BITS-1:0] tick_period,
    input  logic                   tok_valid,
    input  logic [TOKENS_BITS-1:0] tok_data,
    output logic                   tok_ready,
    input  logic                   done,
    input  logic [1:0]             token_startstop,
    output logic                   hold,
    output logic                   clock_slow,
    output logic [ID_BITS-1:0]     processor_id,
    output logic [TOKENS_BITS-1:0] tokens_in,
    output logic                   ev_valid,
    output logic [ID_BITS-1:0]     ev_id,
    output logic [1:0]             ev_startstop,
    output logic                   busy,
    output logic                   timeout,
    output logic [15:0]            tick_count
);

    localparam int CNT_BITS  = $clog2(NUM_PROCESSORS + 1);
    localparam int WAIT_BITS = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, SCAN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    idx_q, idx_d;
    logic [WAIT_BITS-1:0]   wait_q, wait_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;

    logic                   hold_d, clock_slow_d, tok_ready_d, busy_d;
    logic                   ev_valid_d, timeout_d;
    logic [ID_BITS-1:0]     processor_id_d, ev_id_d;
    logic [TOKENS_BITS-1:0] tokens_in_d;
    logic [1:0]             ev_ss_d;
    logic [15:0]            tick_d;

    logic hs, launch, last_load, wait_hit, scan_last;

    assign hs        = ena && (state_q == LOAD) && tok_valid && tok_ready;
    assign launch    = start || (free_run && (period_q == '0));
    assign last_load = (idx_q == CNT_BITS'(NUM_PROCESSORS - 1));
    // done in the final WAIT cycle takes precedence over the timeout
    assign wait_hit  = !done && (wait_q == WAIT_BITS'(DONE_TIMEOUT - 1));
    assign scan_last = (idx_q == CNT_BITS'(NUM_PROCESSORS));

    always_ff @(posedge clk) begin
        if (!rst_n)   state_q <= IDLE;
        else if (ena) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = LOAD;
            LOAD:    if (hs && last_load) state_d = STEP;
            STEP:    state_d = WAIT;
            WAIT:    if (done || wait_hit) state_d = SCAN;
            SCAN:    if (scan_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        hold_d         = !((state_d == STEP) || (state_d == WAIT));
        clock_slow_d   = (state_d != STEP);
        tok_ready_d    = (state_d == LOAD);
        busy_d         = (state_d != IDLE);
        processor_id_d = processor_id;
        tokens_in_d    = hs ? tok_data : '0;
        ev_valid_d     = 1'b0;
        ev_id_d        = ev_id;
        ev_ss_d        = ev_startstop;
        idx_d          = idx_q;
        wait_d         = wait_q;
        period_d       = (period_q == '0) ? '0 : period_q - 1'b1;
        timeout_d      = timeout;
        tick_d         = tick_count;
        case (state_q)
            IDLE: begin
                // reload folds in this cycle's decrement so launches are tick_period apart
                if (launch) period_d = (tick_period == '0) ? '0 : tick_period - 1'b1;
            end
            LOAD: begin
                if (hs) begin
                    processor_id_d = ID_BITS'(idx_q);
                    idx_d          = last_load ? '0 : idx_q + 1'b1;
                end
            end
            STEP: wait_d = '0;
            WAIT: begin
                wait_d = wait_q + 1'b1;
                if (state_d == SCAN) begin
                    processor_id_d = '0;
                    idx_d          = '0;
                    timeout_d      = timeout | wait_hit;
                end
            end
            SCAN: begin
                // idx_q counts scan cycles; the sample now belongs to id idx_q-1
                if ((idx_q != '0) && (token_startstop != 2'b00)) begin
                    ev_valid_d = 1'b1;
                    ev_id_d    = ID_BITS'(idx_q - 1'b1);
                    ev_ss_d    = token_startstop;
                end
                if (scan_last) begin
                    idx_d          = '0;
                    processor_id_d = '0;
                    tick_d         = tick_count + 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (!last_load) processor_id_d = ID_BITS'(idx_q + 1'b1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold         <= 1'b1;
            clock_slow   <= 1'b1;
            tok_ready    <= 1'b0;
            busy         <= 1'b0;
            processor_id <= '0;
            tokens_in    <= '0;
            ev_valid     <= 1'b0;
            ev_id        <= '0;
            ev_startstop <= 2'b00;
            timeout      <= 1'b0;
            tick_count   <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            period_q     <= '0;
        end else if (!ena) begin
            clock_slow   <= 1'b1;
            ev_valid     <= 1'b0;
            tok_ready    <= 1'b0;
            tokens_in    <= '0;
        end else begin
            hold         <= hold_d;
            clock_slow   <= clock_slow_d;
            tok_ready    <= tok_ready_d;
            busy         <= busy_d;
            processor_id <= processor_id_d;
            tokens_in    <= tokens_in_d;
            ev_valid     <= ev_valid_d;
            ev_id        <= ev_id_d;
            ev_startstop <= ev_ss_d;
            timeout      <= timeout_d;
            tick_count   <= tick_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            period_q     <= period_d;
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ticktocktokens_sequencer.sv
// Directed bench for the tick sequencer with a small core model (done delay, token responses).
module tb_tt_um_jleugeri_ticktocktokens_sequencer;

    localparam int ID_BITS = 4;

    logic        clk = 1'b0;
    logic        rst_n, ena, start, free_run;
    logic [15:0] tick_period;
    logic        tok_valid = 1'b0;
    logic [7:0]  tok_data = 8'd0;
    logic        tok_ready;
    logic        done = 1'b0;
    logic [1:0]  token_startstop = 2'b00;
    logic        hold, clock_slow, ev_valid, busy, timeout;
    logic [ID_BITS-1:0] processor_id, ev_id;
    logic [7:0]  tokens_in;
    logic [1:0]  ev_startstop;
    logic [15:0] tick_count;

    tt_um_jleugeri_ticktocktokens_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .free_run(free_run),
        .tick_period(tick_period), .tok_valid(tok_valid), .tok_data(tok_data),
        .tok_ready(tok_ready), .done(done), .token_startstop(token_startstop),
        .hold(hold), .clock_slow(clock_slow), .processor_id(processor_id),
        .tokens_in(tokens_in), .ev_valid(ev_valid), .ev_id(ev_id),
        .ev_startstop(ev_startstop), .busy(busy), .timeout(timeout),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, acc_n = 0, gcnt = 0, wcnt = 0;
    int n_pulse, n_ev, tok_n, tok_sum, tok_bad, pid_bad, n_gap0, n_hold0, n_busy, nl;
    int lt [0:7];
    int done_after = 1;
    bit done_never = 0, gap_mode = 0;
    logic [1:0] resp [0:15];
    logic [ID_BITS-1:0] ev_id_s = '0, prev_pid = '0, last_pid = '0;
    logic [1:0] ev_ss_s = 2'b00;
    logic prev_cs = 1'b1, prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clr_mon();
        n_pulse = 0; n_ev = 0; tok_n = 0; tok_sum = 0; tok_bad = 0; pid_bad = 0;
        n_gap0 = 0; n_hold0 = 0; n_busy = 0; nl = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while (busy && i < lim) begin step(); i++; end
        chk("idle_timeout", busy, 0);
        step();
    endtask

    // token handshakes as the DUT sees them
    always @(posedge clk) begin
        cyc++;
        if (!busy) acc_n = 0;
        else if (rst_n && ena && tok_valid && tok_ready) acc_n++;
    end

    // monitors on settled outputs, then the core model drives its inputs
    always @(negedge clk) begin
        if (prev_cs && !clock_slow) n_pulse++;
        prev_cs = clock_slow;
        if (ev_valid) begin n_ev++; ev_id_s = ev_id; ev_ss_s = ev_startstop; end
        if (tokens_in != 8'd0) begin
            tok_n++; tok_sum += int'(tokens_in);
            if (int'(processor_id) != int'(tokens_in) - 1) tok_bad++;
        end else if (tok_ready) begin
            n_gap0++;
            if (processor_id != prev_pid) pid_bad++;
        end
        prev_pid = processor_id;
        if (!hold) n_hold0++;
        if (busy) n_busy++;
        if (busy && !prev_busy) begin if (nl < 8) lt[nl] = cyc; nl++; end
        prev_busy = busy;
        if (!hold && clock_slow) wcnt++;
        else if (hold) wcnt = 0;
        done = !done_never && (wcnt != 0) && (wcnt >= done_after);
        token_startstop = resp[last_pid];
        last_pid = processor_id;
        tok_valid = gap_mode ? (gcnt % 3 == 0) : 1'b1;
        gcnt++;
        tok_data = 8'(acc_n + 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, i, frz_bad;
        for (int k = 0; k < 16; k++) resp[k] = 2'b00;
        rst_n = 1'b0; start = 1'b1; ena = 1'b1; free_run = 1'b0; tick_period = 16'd40;
        clr_mon();
        step(); step();
        // T1 reset with start held
        chk("rst_hold", hold, 1);
        chk("rst_clock_slow", clock_slow, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick_count, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_tok_ready", tok_ready, 0);
        rst_n = 1'b1; start = 1'b0;
        step();
        chk("idle_after_rst", busy, 0);

        // T2 single streamed tick, done after 3 WAIT cycles, event from id 4
        resp[4] = 2'b01; done_after = 3; gap_mode = 0;
        clr_mon(); pulse_start(); wait_idle(200);
        chk("t2_pulses", n_pulse, 1);
        chk("t2_events", n_ev, 1);
        chk("t2_ev_id", ev_id_s, 4);
        chk("t2_ev_ss", ev_ss_s, 1);
        chk("t2_tick", tick_count, 1);
        chk("t2_tok_n", tok_n, 10);
        chk("t2_tok_sum", tok_sum, 55);
        chk("t2_tok_pid", tok_bad, 0);
        chk("t2_hold_low", n_hold0, 4);
        chk("t2_busy_len", n_busy, 25);

        // T3 gapped token stream
        gap_mode = 1; done_after = 1;
        clr_mon(); pulse_start(); wait_idle(300);
        chk("t3_tok_n", tok_n, 10);
        chk("t3_tok_sum", tok_sum, 55);
        chk("t3_tok_pid", tok_bad, 0);
        chk("t3_pid_hold", pid_bad, 0);
        chk("t3_gap_zero", n_gap0 >= 18, 1);
        chk("t3_tick", tick_count, 2);
        gap_mode = 0;

        // done in the timeout cycle wins; a start while busy is dropped
        done_after = 255;
        clr_mon(); pulse_start();
        repeat (20) step();
        pulse_start();
        wait_idle(400);
        chk("t3b_no_timeout", timeout, 0);
        chk("t3b_hold_low", n_hold0, 256);
        chk("t3b_tick", tick_count, 3);
        step();
        chk("t3b_start_dropped", busy, 0);

        // T4 done never comes
        done_never = 1;
        clr_mon(); pulse_start(); wait_idle(400);
        chk("t4_timeout", timeout, 1);
        chk("t4_hold_low", n_hold0, 256);
        chk("t4_tick", tick_count, 4);
        chk("t4_events", n_ev, 1);
        done_never = 0; done_after = 1;
        clr_mon(); pulse_start(); wait_idle(200);
        chk("t4_sticky", timeout, 1);
        chk("t4_tick2", tick_count, 5);

        // T5 free-running at period 40, then back-to-back
        clr_mon(); free_run = 1'b1;
        i = 0;
        while (nl < 3 && i < 300) begin step(); i++; end
        chk("t5_launches", nl >= 3, 1);
        chk("t5_gap1", lt[1] - lt[0], 40);
        chk("t5_gap2", lt[2] - lt[1], 40);
        tick_period = 16'd0; nl = 0;
        i = 0;
        while (nl < 3 && i < 300) begin step(); i++; end
        chk("t5_launches_b2b", nl >= 3, 1);
        chk("t5_b2b_gap1", lt[1] - lt[0], 24);
        chk("t5_b2b_gap2", lt[2] - lt[1], 24);
        free_run = 1'b0; tick_period = 16'd40;
        wait_idle(100);

        // ena freeze in WAIT
        done_after = 3; clr_mon(); t0 = int'(tick_count);
        pulse_start();
        i = 0;
        while (!(busy && !hold && clock_slow) && i < 50) begin step(); i++; end
        chk("t5_in_wait", {busy, hold, clock_slow}, 3'b101);
        ena = 1'b0; frz_bad = 0;
        repeat (5) begin
            step();
            if (!busy || hold || !clock_slow) frz_bad++;
        end
        ena = 1'b1;
        chk("t5_frozen", frz_bad, 0);
        wait_idle(100);
        chk("t5_frz_pulses", n_pulse, 1);
        chk("t5_frz_hold_low", n_hold0, 7);
        chk("t5_frz_tick", tick_count, t0 + 1);

        // T6 reset in the middle of SCAN
        done_after = 1; clr_mon(); pulse_start();
        i = 0;
        while (hold && i < 50) begin step(); i++; end
        while (!hold && i < 100) begin step(); i++; end
        chk("t6_in_scan", {busy, hold}, 2'b11);
        step(); step();
        rst_n = 1'b0; step();
        chk("t6_hold", hold, 1);
        chk("t6_clock_slow", clock_slow, 1);
        chk("t6_busy", busy, 0);
        chk("t6_pid", processor_id, 0);
        chk("t6_tokens_in", tokens_in, 0);
        chk("t6_tok_ready", tok_ready, 0);
        chk("t6_ev", {ev_valid, ev_id, ev_startstop}, 0);
        chk("t6_timeout", timeout, 0);
        chk("t6_tick", tick_count, 0);
        rst_n = 1'b1;
        repeat (15) step();
        chk("t6_no_event", n_ev, 0);
        chk("t6_stays_idle", busy, 0);
        chk("t6_tick_after", tick_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
